// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC owner, 64->32 instruction select, valid/ready output with 1-entry skid.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_stage #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_read,
    input  logic [2*INST_W-1:0]   mem_data,
    output logic [INST_W-1:0]     id_inst,
    output logic [ADDR_W-1:0]     id_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    input  logic                  br_valid,
    input  logic [ADDR_W-1:0]     br_target
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   pc, pend_pc, skid_pc;
    logic [INST_W-1:0]   skid_inst, sel_inst;
    logic                pend, issue, out_free;

    assign out_free = !id_valid || id_ready;
    assign sel_inst = pend_pc[2] ? mem_data[2*INST_W-1:INST_W] : mem_data[INST_W-1:0];
    assign mem_read = issue;
    assign mem_addr = pc;

    // Issue is held off whenever returning data would have to go to the skid,
    // so at most one entry ever lands there.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            IDLE:  state_nx = RUN;
            RUN: begin
                issue = !br_valid && !(pend && id_valid && !id_ready);
                if (pend && !out_free) state_nx = STALL;
            end
            STALL: if (id_ready) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
        if (br_valid) state_nx = RUN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            pend      <= 1'b0;
            pend_pc   <= '0;
            skid_pc   <= '0;
            skid_inst <= '0;
            id_valid  <= 1'b0;
            id_inst   <= '0;
            id_pc     <= '0;
        end else if (br_valid) begin
            pc       <= br_target & ~ADDR_W'(3);
            pend     <= 1'b0;
            id_valid <= 1'b0;
        end else begin
            pend <= issue;
            if (issue) begin
                pend_pc <= pc;
                pc      <= pc + STEP;
            end
            if (state == STALL) begin
                if (id_ready) begin
                    id_inst  <= skid_inst;
                    id_pc    <= skid_pc;
                    id_valid <= 1'b1;
                end
            end else if (pend) begin
                if (out_free) begin
                    id_inst  <= sel_inst;
                    id_pc    <= pend_pc;
                    id_valid <= 1'b1;
                end else begin
                    skid_inst <= sel_inst;
                    skid_pc   <= pend_pc;
                end
            end else if (id_ready) begin
                id_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (id_valid && id_ready)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (id_valid && !id_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
